// File: rtl/sc_et_pkg.sv
// Shared types and helpers for the early-termination stochastic-computing decoder.
package sc_et_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_et_state_t;

    // Clamp a requested precision into the legal range 1..w.
    function automatic int unsigned clamp_prec(input int unsigned p, input int unsigned w);
        if (p < 1) begin
            return 1;
        end
        if (p > w) begin
            return w;
        end
        return p;
    endfunction

endpackage

// File: rtl/sc_et_bound.sv
// Early-termination test: the result quantized to 2^s cannot change when every
// remaining bit of the nominal 2^W stream is a one.
module sc_et_bound #(
    parameter  int W  = 6,
    localparam int PW = $clog2(W + 1)
) (
    input  logic [W:0]    c,
    input  logic [W:0]    k,
    input  logic [PW-1:0] s,
    output logic          term
);

    localparam logic [W+1:0] L_EXT = (W + 2)'(1) << W;

    logic [W+1:0] c_ext;
    logic [W+1:0] hi_ext;

    // c <= k always holds, so c + L - k never underflows and stays <= L.
    assign c_ext  = {1'b0, c};
    assign hi_ext = c_ext + L_EXT - {1'b0, k};
    assign term   = (c_ext >> s) == (hi_ext >> s);

endmodule

// File: rtl/sc_et_decoder.sv
// Progressive early-termination decoder: counts ones of a unipolar stream and stops
// as soon as the remaining bits cannot alter the result at the latched precision.
module sc_et_decoder
    import sc_et_pkg::*;
#(
    parameter  int W  = 6,
    localparam int PW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [PW-1:0] prec,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          in_ready,
    output logic [W:0]    Bz,
    output logic [W:0]    used,
    output logic          done
);

    sc_et_state_t  state_q, state_d;
    logic [W:0]    c_q, c_d;
    logic [W:0]    k_q, k_d;
    logic [PW-1:0] s_q, s_d;
    logic [W:0]    bz_q, bz_d;
    logic [W:0]    used_q, used_d;

    logic [W:0]    c_inc;
    logic [W:0]    k_inc;
    logic [PW-1:0] s_new;
    logic          term;

    assign c_inc = c_q + {{W{1'b0}}, in_bit};
    assign k_inc = k_q + (W + 1)'(1);
    assign s_new = PW'(W - clamp_prec(32'(prec), W));

    // The bound is evaluated on the post-beat counters so termination takes effect
    // on the same edge that accepts the deciding bit.
    sc_et_bound #(.W(W)) u_bound (
        .c    (c_inc),
        .k    (k_inc),
        .s    (s_q),
        .term (term)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        k_d     = k_q;
        s_d     = s_q;
        bz_d    = bz_q;
        used_d  = used_q;
        if (start) begin
            // Restart from any state; a beat offered alongside start is dropped.
            state_d = RUN;
            c_d     = '0;
            k_d     = '0;
            s_d     = s_new;
            bz_d    = '0;
            used_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (in_valid) begin
                        c_d = c_inc;
                        k_d = k_inc;
                        if (term) begin
                            state_d = DONE;
                            bz_d    = (c_inc >> s_q) << s_q;
                            used_d  = k_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            k_q     <= '0;
            s_q     <= '0;
            bz_q    <= '0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
            s_q     <= s_d;
            bz_q    <= bz_d;
            used_q  <= used_d;
        end
    end

    assign in_ready = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign Bz       = bz_q;
    assign used     = used_q;

endmodule

// File: tb/tb_sc_et_decoder.sv
// Scoreboard bench for sc_et_decoder: stimulus queues expected Bz/used per run,
// a monitor pops and compares on each rising edge of done.
module tb_sc_et_decoder;

    localparam int W      = 6;
    localparam int PW     = $clog2(W + 1);
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] prec = '0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_ready;
    logic [W:0]    Bz;
    logic [W:0]    used;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [2*W+1:0] exp_q[$];

    always #5 clk = ~clk;

    sc_et_decoder #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .prec     (prec),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .in_ready (in_ready),
        .Bz       (Bz),
        .used     (used),
        .done     (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares the result of each completed conversion against the queue.
    initial begin
        logic done_prev;
        logic [2*W+1:0] e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: Bz=%0d used=%0d with empty queue", Bz, used);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_Bz", int'(Bz), int'(e[2*W+1:W+1]));
                    chk("result_used", int'(used), int'(e[W:0]));
                    $display("conversion: Bz=%0d used=%0d (expected Bz=%0d used=%0d)",
                             Bz, used, e[2*W+1:W+1], e[W:0]);
                end
            end
            done_prev = done;
        end
    end

    task automatic issue_start(input int p);
        prec     = PW'(p);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_after_start", int'(in_ready), 1);
        chk("Bz_zero_in_run", int'(Bz), 0);
        chk("used_zero_in_run", int'(used), 0);
    endtask

    // Offer bits (first `ones` accepted bits are 1) until done, `limit` beats, or budget.
    task automatic feed(input int limit, input int ones, input bit stall,
                        output int beats, output bit got_done);
        int cyc;
        bit acc;
        cyc   = 0;
        beats = 0;
        while (!done && beats < limit && cyc < BUDGET) begin
            in_valid = stall ? ((cyc % 2) == 0) : 1'b1;
            in_bit   = (beats < ones);
            acc      = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) beats++;
            cyc++;
        end
        in_valid = 1'b0;
        got_done = done;
    endtask

    task automatic finish_check(input int beats, input bit got, input int exp_used);
        chk("done_within_budget", int'(got), 1);
        chk("beats_accepted", beats, exp_used);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        chk("ready_low_after_done", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("done_held", int'(done), 1);
        in_valid = 1'b0;
    endtask

    task automatic run(input int p, input int ones, input bit stall,
                       input int exp_bz, input int exp_used);
        int  beats;
        bit  got;
        exp_q.push_back({(W + 1)'(exp_bz), (W + 1)'(exp_used)});
        issue_start(p);
        feed(1000, ones, stall, beats, got);
        finish_check(beats, got, exp_used);
    endtask

    initial begin
        int beats;
        bit got;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_Bz", int'(Bz), 0);
        chk("reset_used", int'(used), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", int'(in_ready), 0);

        run(6, 0, 1'b0, 0, 64);    // full precision, all zeros
        run(2, 16, 1'b0, 16, 49);  // c=16 settles once rem<=15
        run(1, 0, 1'b0, 0, 33);
        run(1, 64, 1'b0, 64, 64);
        run(2, 16, 1'b1, 16, 49);  // stalled stream, same result
        run(0, 0, 1'b0, 0, 33);    // prec 0 clamps to 1
        run(7, 0, 1'b0, 0, 64);    // prec 7 clamps to W

        // Abort at beat 20 with a valid 1 offered alongside start.
        issue_start(6);
        feed(20, 0, 1'b0, beats, got);
        chk("abort_prefix_beats", beats, 20);
        exp_q.push_back({(W + 1)'(64), (W + 1)'(64)});
        prec     = PW'(6);
        start    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("restart_ready", int'(in_ready), 1);
        feed(1000, 64, 1'b0, beats, got);
        finish_check(beats, got, 64);

        // Asynchronous reset mid-run, then an independent prec=3 run.
        issue_start(6);
        feed(10, 10, 1'b0, beats, got);
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", int'(in_ready), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_Bz", int'(Bz), 0);
        chk("midreset_used", int'(used), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", int'(in_ready), 0);
        run(3, 12, 1'b0, 8, 61);   // c=12, S=3: settles when rem<=3

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
